// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle RV32I controller.
// Optional feature macro: RV_UPPER_IMM_EN (adds lui/auipc via EXECUTEU).
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BRANCH,
    S_JAL
`ifdef RV_UPPER_IMM_EN
    , S_EXECUTEU
`endif
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation select: forced add/sub, or derived from funct fields.
module alu_decoder
  import multicycle_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [3:0] alucontrol
);

  // R-type passes funct7b5 through; I-type only honours it for srai
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        if (op5) alucontrol = {funct7b5, funct3};
        else     alucontrol = {funct7b5 & (funct3 == 3'b101), funct3};
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for a multicycle RV32I core with a shared ALU and memory port.
// Optional feature macro: RV_UPPER_IMM_EN (lui/auipc through EXECUTEU).
module multicycle_controller
  import multicycle_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       InstrDone,
  output logic       IllegalInstr
);

  state_t state, next_state;
  aluop_t aluop;

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .alucontrol (ALUControl)
  );

  // State register with synchronous reset back to FETCH
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // Next state and Moore outputs; reset masks every enable and strobe
  always_comb begin
    next_state   = state;
    PCWrite      = 1'b0;
    AdrSrc       = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    ResultSrc    = RES_ALUOUT;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_RS2;
    aluop        = ALUOP_ADD;
    InstrDone    = 1'b0;
    IllegalInstr = 1'b0;

    case (state)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
        if (MemReady) next_state = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECUTER;
          OP_ITYPE:          next_state = S_EXECUTEI;
          OP_JAL:            next_state = S_JAL;
          OP_BRANCH: begin
            if (funct3[2:1] == 2'b00) begin
              next_state = S_BRANCH;
            end else begin
              next_state   = S_FETCH;
              IllegalInstr = 1'b1;
            end
          end
`ifdef RV_UPPER_IMM_EN
          OP_LUI, OP_AUIPC:  next_state = S_EXECUTEU;
`endif
          default: begin
            next_state   = S_FETCH;
            IllegalInstr = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (MemReady) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        RegWrite   = 1'b1;
        InstrDone  = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        MemWrite  = 1'b1;
        InstrDone = MemReady;
        if (MemReady) next_state = S_FETCH;
      end
      S_EXECUTER: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        aluop      = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        aluop      = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        InstrDone  = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        aluop      = ALUOP_SUB;
        PCWrite    = Zero ^ funct3[0];
        InstrDone  = 1'b1;
        next_state = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        PCWrite    = 1'b1;
        next_state = S_ALUWB;
      end
`ifdef RV_UPPER_IMM_EN
      S_EXECUTEU: begin
        ALUSrcA    = (op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
        ALUSrcB    = SRCB_IMM;
        next_state = S_ALUWB;
      end
`endif
      default: next_state = S_FETCH;
    endcase

    if (reset) begin
      PCWrite      = 1'b0;
      IRWrite      = 1'b0;
      RegWrite     = 1'b0;
      MemWrite     = 1'b0;
      InstrDone    = 1'b0;
      IllegalInstr = 1'b0;
    end
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_STORE:  ImmSrc = IMM_S;
      OP_BRANCH: ImmSrc = IMM_B;
      OP_JAL:    ImmSrc = IMM_J;
`ifdef RV_UPPER_IMM_EN
      OP_LUI, OP_AUIPC: ImmSrc = IMM_U;
`endif
      default:   ImmSrc = IMM_I;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed cycle-by-cycle check of the multicycle controller outputs.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       InstrDone, IllegalInstr;

  int tests = 0;
  int fails = 0;

  multicycle_controller dut (
    .clk          (clk),
    .reset        (reset),
    .op           (op),
    .funct3       (funct3),
    .funct7b5     (funct7b5),
    .Zero         (Zero),
    .MemReady     (MemReady),
    .PCWrite      (PCWrite),
    .AdrSrc       (AdrSrc),
    .MemWrite     (MemWrite),
    .IRWrite      (IRWrite),
    .RegWrite     (RegWrite),
    .ResultSrc    (ResultSrc),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ImmSrc       (ImmSrc),
    .ALUControl   (ALUControl),
    .InstrDone    (InstrDone),
    .IllegalInstr (IllegalInstr)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input logic mr);
    op = o; funct3 = f3; funct7b5 = f7; Zero = z; MemReady = mr;
  endtask

  // One cycle: settle, compare the full control vector (and optionally ImmSrc), advance
  task automatic cyc(input string tag, input logic pcw, input logic adr, input logic mw,
                     input logic irw, input logic rw, input logic [1:0] rs,
                     input logic [1:0] sa, input logic [1:0] sb, input logic [3:0] alc,
                     input logic done, input logic ill, input logic imm_en,
                     input logic [2:0] imm);
    logic [16:0] obs, exp;
    #1;
    obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, InstrDone, IllegalInstr};
    exp = {pcw, adr, mw, irw, rw, rs, sa, sb, alc, done, ill};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s ctl observed=%b expected=%b", tag, obs, exp);
    end
    if (imm_en) begin
      tests++;
      assert (ImmSrc === imm) else begin
        fails++;
        $error("FAIL %s ImmSrc observed=%b expected=%b", tag, ImmSrc, imm);
      end
    end
    @(negedge clk);
  endtask

  // Cycle under reset: every enable and strobe must be low
  task automatic rst_cyc(input string tag);
    logic [5:0] obs;
    #1;
    obs = {PCWrite, IRWrite, RegWrite, MemWrite, InstrDone, IllegalInstr};
    tests++;
    assert (obs === 6'b0) else begin
      fails++;
      $error("FAIL %s enables observed=%b expected=000000", tag, obs);
    end
    @(negedge clk);
  endtask

  task automatic fetch(input string tag);
    cyc(tag, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 4'b0000, 0, 0, 0, 3'b000);
  endtask

  task automatic decode(input string tag);
    cyc(tag, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'b0000, 0, 0, 0, 3'b000);
  endtask

  task automatic aluwb(input string tag);
    cyc(tag, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'b0000, 1, 0, 0, 3'b000);
  endtask

  initial begin
    reset = 1'b1;
    drive(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    rst_cyc("rst_init");
    reset = 1'b0;

    // lw x1,4(x2), no wait states: 5 cycles
    fetch("lw_fetch");
    decode("lw_decode");
    cyc("lw_memadr", 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'b0000, 0, 0, 1, 3'b000);
    cyc("lw_memread", 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 0, 0, 0, 3'b000);
    cyc("lw_memwb", 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 4'b0000, 1, 0, 0, 3'b000);

    // lw again: fetch stall, then reset held 3 cycles during MEMREAD wait
    drive(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
    cyc("fetch_stall", 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 4'b0000, 0, 0, 0, 3'b000);
    MemReady = 1'b1;
    fetch("lw2_fetch");
    decode("lw2_decode");
    cyc("lw2_memadr", 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'b0000, 0, 0, 0, 3'b000);
    MemReady = 1'b0;
    cyc("lw2_memread_wait", 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 0, 0, 0, 3'b000);
    reset = 1'b1;
    MemReady = 1'b1;
    rst_cyc("rst_mid_1");
    rst_cyc("rst_mid_2");
    rst_cyc("rst_mid_3");
    reset = 1'b0;

    // sw with MemReady low 2 cycles in MEMWRITE: 6 cycles
    drive(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
    fetch("rst_release_fetch");
    decode("sw_decode");
    cyc("sw_memadr", 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'b0000, 0, 0, 1, 3'b001);
    MemReady = 1'b0;
    cyc("sw_memwrite_w1", 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 0, 0, 0, 3'b000);
    cyc("sw_memwrite_w2", 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 0, 0, 0, 3'b000);
    MemReady = 1'b1;
    cyc("sw_memwrite_rdy", 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 1, 0, 0, 3'b000);

    // beq taken, Zero=1
    drive(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b1);
    fetch("beq_fetch");
    decode("beq_decode");
    cyc("beq_branch", 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'b1000, 1, 0, 1, 3'b010);

    // bne not taken, Zero=1
    drive(7'b1100011, 3'b001, 1'b0, 1'b1, 1'b1);
    fetch("bne_fetch");
    decode("bne_decode");
    cyc("bne_branch", 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'b1000, 1, 0, 0, 3'b000);

    // sub x3,x1,x2
    drive(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b1);
    fetch("sub_fetch");
    decode("sub_decode");
    cyc("sub_exec", 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'b1000, 0, 0, 0, 3'b000);
    aluwb("sub_aluwb");

    // srai
    drive(7'b0010011, 3'b101, 1'b1, 1'b0, 1'b1);
    fetch("srai_fetch");
    decode("srai_decode");
    cyc("srai_exec", 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'b1101, 0, 0, 1, 3'b000);
    aluwb("srai_aluwb");

    // addi with Instr[30]=1 stays an add
    drive(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b1);
    fetch("addi_fetch");
    decode("addi_decode");
    cyc("addi_exec", 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'b0000, 0, 0, 0, 3'b000);
    aluwb("addi_aluwb");

    // jal
    drive(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b1);
    fetch("jal_fetch");
    cyc("jal_decode", 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'b0000, 0, 0, 1, 3'b011);
    cyc("jal_jal", 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 4'b0000, 0, 0, 0, 3'b000);
    aluwb("jal_aluwb");

    // blt is not supported: illegal pulse in DECODE, back to FETCH
    drive(7'b1100011, 3'b100, 1'b0, 1'b0, 1'b1);
    fetch("blt_fetch");
    cyc("blt_decode", 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'b0000, 0, 1, 0, 3'b000);

    // lui
    drive(7'b0110111, 3'b000, 1'b0, 1'b0, 1'b1);
    fetch("lui_fetch");
`ifdef RV_UPPER_IMM_EN
    cyc("lui_decode", 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'b0000, 0, 0, 1, 3'b100);
    cyc("lui_execu", 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 4'b0000, 0, 0, 1, 3'b100);
    aluwb("lui_aluwb");
`else
    cyc("lui_decode", 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'b0000, 0, 1, 1, 3'b000);
`endif
    fetch("final_fetch");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
